// File: rtl/vga_sync_gen.sv
// ---------------------------------------------------------------------------
// vga_sync_gen
//
// VGA timing generator. A clock divider produces the pixel-rate advance, and
// horizontal/vertical counters walk the raster. Every output is registered
// and decoded from the counter values the counters are about to take, so all
// outputs change on the same edge and stay mutually aligned.
//
// Defaults give 640x480 at 60 Hz from a 50 MHz clock (25 MHz pixel rate).
//
// Ports:
//   clk          system clock; all logic on the rising edge
//   reset        asynchronous, active-low reset
//   hsync        horizontal sync, active at SYNC_POL
//   vsync        vertical sync, active at SYNC_POL
//   video_on     high while the current pixel is inside the visible area
//   p_tick       one-clk pulse marking a new pixel on the outputs
//   pixel_x      current horizontal count
//   pixel_y      current vertical count
//   frame_start  one-clk pulse when the counters enter (0,0)
//
// Flow control: there is none. The block free-runs with no valid/ready
// handshake; a consumer samples pixel_x/pixel_y/video_on/hsync/vsync in any
// cycle where p_tick is 1, and those values hold until the next p_tick.
// ---------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int   CLK_DIV   = 2,
  parameter int   H_DISPLAY = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_DISPLAY = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic SYNC_POL  = 1'b0,
  parameter int   CNT_W     = 10
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_DISPLAY + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_DISPLAY + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div;
  logic             advance;
  logic             h_wrap;
  logic [CNT_W-1:0] h_next;
  logic [CNT_W-1:0] v_next;
  logic             video_next;
  logic             hsync_next;
  logic             vsync_next;
  logic             frame_next;

  // pixel_x / pixel_y are the counters themselves; the decode looks at the
  // next-state values so the registered outputs line up with the counters.
  always_comb begin
    advance    = (div == DIV_LAST);
    h_wrap     = advance && (pixel_x == H_LAST);
    h_next     = pixel_x;
    v_next     = pixel_y;
    if (advance) begin
      h_next = h_wrap ? '0 : pixel_x + CNT_W'(1);
    end
    if (h_wrap) begin
      v_next = (pixel_y == V_LAST) ? '0 : pixel_y + CNT_W'(1);
    end
    video_next = (h_next < H_VIS) && (v_next < V_VIS);
    hsync_next = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
    vsync_next = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
    frame_next = advance && (h_next == '0) && (v_next == '0);
  end

  // Reset parks the raster on the last pixel of the frame so the first
  // advance after release lands on (0,0) and raises frame_start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div         <= '0;
      pixel_x     <= H_LAST;
      pixel_y     <= V_LAST;
      video_on    <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      p_tick      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= advance ? '0 : div + DIV_W'(1);
      pixel_x     <= h_next;
      pixel_y     <= v_next;
      video_on    <= video_next;
      hsync       <= hsync_next;
      vsync       <= vsync_next;
      p_tick      <= advance;
      frame_start <= frame_next;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Four instances share one clock and one reset:
//   0 dflt : default 640x480 timing, CLK_DIV=2
//   1 div1 : default timing, CLK_DIV=1
//   2 sm   : tiny raster 15x11, CLK_DIV=2, active-low sync
//   3 d3   : tiny raster 11x8,  CLK_DIV=3, active-high sync
// A reference model maps "edges since reset release" onto a linear raster
// position with plain arithmetic and decodes the outputs from it.
// ---------------------------------------------------------------------------
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       video;
    logic       hs;
    logic       vs;
    logic       tick;
    logic       fs;
  } obs_t;

  typedef struct {
    int   div;
    int   hd, hfp, hsw, hbp;
    int   vd, vfp, vsw, vbp;
    logic pol;
  } tim_t;

  typedef struct {
    int   inst;
    int   n;
    obs_t exp;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  logic       d_hs, d_vs, d_vid, d_tick, d_fs;
  logic [9:0] d_x, d_y;
  logic       o_hs, o_vs, o_vid, o_tick, o_fs;
  logic [9:0] o_x, o_y;
  logic       s_hs, s_vs, s_vid, s_tick, s_fs;
  logic [3:0] s_x, s_y;
  logic       t_hs, t_vs, t_vid, t_tick, t_fs;
  logic [3:0] t_x, t_y;

  vga_sync_gen u_dflt (
    .clk(clk), .reset(reset), .hsync(d_hs), .vsync(d_vs), .video_on(d_vid),
    .p_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y), .frame_start(d_fs)
  );

  vga_sync_gen #(.CLK_DIV(1)) u_div1 (
    .clk(clk), .reset(reset), .hsync(o_hs), .vsync(o_vs), .video_on(o_vid),
    .p_tick(o_tick), .pixel_x(o_x), .pixel_y(o_y), .frame_start(o_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_DISPLAY(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b0), .CNT_W(4)
  ) u_sm (
    .clk(clk), .reset(reset), .hsync(s_hs), .vsync(s_vs), .video_on(s_vid),
    .p_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y), .frame_start(s_fs)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_DISPLAY(5), .H_FP(1), .H_SYNC(2), .H_BP(3),
    .V_DISPLAY(4), .V_FP(2), .V_SYNC(1), .V_BP(1), .SYNC_POL(1'b1), .CNT_W(4)
  ) u_d3 (
    .clk(clk), .reset(reset), .hsync(t_hs), .vsync(t_vs), .video_on(t_vid),
    .p_tick(t_tick), .pixel_x(t_x), .pixel_y(t_y), .frame_start(t_fs)
  );

  // ---------------- bookkeeping ----------------
  int    n_cmp = 0;
  int    n_fail = 0;
  int    n = 0;           // rising edges since reset release
  tim_t  tims[4];
  string names[4];
  vec_t  tbl[$];

  function automatic obs_t mk(int x, int y, logic v, logic h, logic vs, logic t, logic f);
    obs_t r;
    r.x = 10'(x); r.y = 10'(y);
    r.video = v; r.hs = h; r.vs = vs; r.tick = t; r.fs = f;
    return r;
  endfunction

  function automatic obs_t get_obs(int i);
    obs_t r;
    case (i)
      0:       r = {d_x, d_y, d_vid, d_hs, d_vs, d_tick, d_fs};
      1:       r = {o_x, o_y, o_vid, o_hs, o_vs, o_tick, o_fs};
      2:       r = {6'd0, s_x, 6'd0, s_y, s_vid, s_hs, s_vs, s_tick, s_fs};
      default: r = {6'd0, t_x, 6'd0, t_y, t_vid, t_hs, t_vs, t_tick, t_fs};
    endcase
    return r;
  endfunction

  // Reference model: after reset the raster sits on the last pixel of the
  // frame; every CLK_DIV edges it moves one linear position forward.
  function automatic obs_t model(tim_t t, int edges);
    obs_t r;
    int ht, vt, total, adv, p, x, y;
    ht    = t.hd + t.hfp + t.hsw + t.hbp;
    vt    = t.vd + t.vfp + t.vsw + t.vbp;
    total = ht * vt;
    adv   = edges / t.div;
    p     = (total - 1 + adv) % total;
    x     = p % ht;
    y     = p / ht;
    r.x     = 10'(x);
    r.y     = 10'(y);
    r.video = (x < t.hd) && (y < t.vd);
    r.hs    = (x >= t.hd + t.hfp && x < t.hd + t.hfp + t.hsw) ? t.pol : ~t.pol;
    r.vs    = (y >= t.vd + t.vfp && y < t.vd + t.vfp + t.vsw) ? t.pol : ~t.pol;
    r.tick  = (edges >= 1) && (edges % t.div == 0);
    r.fs    = r.tick && (p == 0);
    return r;
  endfunction

  task automatic check(string name, obs_t got, obs_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d: got x=%0d y=%0d vid=%b hs=%b vs=%b tick=%b fs=%b, expected x=%0d y=%0d vid=%b hs=%b vs=%b tick=%b fs=%b",
               name, n, got.x, got.y, got.video, got.hs, got.vs, got.tick, got.fs,
               exp.x, exp.y, exp.video, exp.hs, exp.vs, exp.tick, exp.fs);
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) check(names[i], get_obs(i), model(tims[i], n));
  endtask

  task automatic check_table();
    foreach (tbl[k]) begin
      if (tbl[k].n == n) check($sformatf("vec_%s", names[tbl[k].inst]), get_obs(tbl[k].inst), tbl[k].exp);
    end
  endtask

  task automatic add(int inst, int edges, obs_t e);
    vec_t v;
    v.inst = inst; v.n = edges; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic step();
    @(posedge clk);
    n++;
    @(negedge clk);
    check_all();
  endtask

  // Async reset between edges; outputs must already show reset values.
  task automatic async_reset(int off, int hold);
    #(off);
    reset = 1'b0;
    n = 0;
    #1;
    check("dflt_async_rst", get_obs(0), mk(799, 524, 0, 1, 1, 0, 0));
    check_all();
    repeat (hold) begin
      @(negedge clk);
      check_all();
    end
    reset = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  int   tick_l0, vid_l0, hs_l0;
  int   d_first, d_second, o_first, o_second;
  int   waited;
  obs_t g;

  initial begin
    tims[0] = '{2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    tims[1] = '{1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0};
    tims[2] = '{2, 8, 2, 3, 2, 6, 1, 2, 2, 1'b0};
    tims[3] = '{3, 5, 1, 2, 3, 4, 2, 1, 1, 1'b1};
    names[0] = "dflt"; names[1] = "div1"; names[2] = "sm"; names[3] = "d3";

    // Hand-derived vectors: {instance, edges since release, expected outputs}
    add(0, 0,    mk(799, 524, 0, 1, 1, 0, 0));
    add(0, 1,    mk(799, 524, 0, 1, 1, 0, 0));
    add(0, 2,    mk(0,   0,   1, 1, 1, 1, 1));
    add(0, 3,    mk(0,   0,   1, 1, 1, 0, 0));
    add(0, 4,    mk(1,   0,   1, 1, 1, 1, 0));
    add(0, 1280, mk(639, 0,   1, 1, 1, 1, 0));
    add(0, 1281, mk(639, 0,   1, 1, 1, 0, 0));
    add(0, 1282, mk(640, 0,   0, 1, 1, 1, 0));
    add(0, 1312, mk(655, 0,   0, 1, 1, 1, 0));
    add(0, 1314, mk(656, 0,   0, 0, 1, 1, 0));
    add(0, 1504, mk(751, 0,   0, 0, 1, 1, 0));
    add(0, 1506, mk(752, 0,   0, 1, 1, 1, 0));
    add(0, 1600, mk(799, 0,   0, 1, 1, 1, 0));
    add(0, 1602, mk(0,   1,   1, 1, 1, 1, 0));
    add(1, 0,    mk(799, 524, 0, 1, 1, 0, 0));
    add(1, 1,    mk(0,   0,   1, 1, 1, 1, 1));
    add(1, 2,    mk(1,   0,   1, 1, 1, 1, 0));
    add(1, 640,  mk(639, 0,   1, 1, 1, 1, 0));
    add(1, 641,  mk(640, 0,   0, 1, 1, 1, 0));
    add(1, 801,  mk(0,   1,   1, 1, 1, 1, 0));
    add(2, 22,   mk(10,  0,   0, 0, 1, 1, 0));
    add(2, 23,   mk(10,  0,   0, 0, 1, 0, 0));
    add(2, 180,  mk(14,  5,   0, 1, 1, 1, 0));
    add(2, 182,  mk(0,   6,   0, 1, 1, 1, 0));
    add(2, 212,  mk(0,   7,   0, 1, 0, 1, 0));
    add(2, 330,  mk(14,  10,  0, 1, 1, 1, 0));
    add(2, 332,  mk(0,   0,   1, 1, 1, 1, 1));
    add(3, 0,    mk(10,  7,   0, 0, 0, 0, 0));
    add(3, 3,    mk(0,   0,   1, 0, 0, 1, 1));

    // Reset held: reset values on every instance.
    repeat (3) @(negedge clk);
    check("dflt_reset", get_obs(0), mk(799, 524, 0, 1, 1, 0, 0));
    check("d3_reset", get_obs(3), mk(10, 7, 0, 0, 0, 0, 0));
    check_all();

    // Startup and line timing over the first two default lines.
    reset = 1'b1;
    n = 0;
    check_table();
    tick_l0 = 0; vid_l0 = 0; hs_l0 = 0;
    d_first = -1; d_second = -1; o_first = -1; o_second = -1;
    for (int i = 0; i < 3300; i++) begin
      step();
      check_table();
      g = get_obs(0);
      if (g.tick && g.y == 10'd0) begin
        tick_l0++;
        if (g.video) vid_l0++;
        if (!g.hs) hs_l0++;
      end
      if (g.tick && g.x == 10'd0) begin
        if (d_first < 0) d_first = n; else if (d_second < 0) d_second = n;
      end
      g = get_obs(1);
      if (g.tick && g.x == 10'd0) begin
        if (o_first < 0) o_first = n; else if (o_second < 0) o_second = n;
      end
    end
    check_int("line0_ticks", tick_l0, 800);
    check_int("line0_video_ticks", vid_l0, 640);
    check_int("line0_hsync_ticks", hs_l0, 96);
    check_int("dflt_line_period_clks", d_second - d_first, 1600);
    check_int("div1_line_period_clks", o_second - o_first, 800);

    // Mid-frame reset on the default raster at pixel_x == 300.
    waited = 0;
    while (get_obs(0).x != 10'd300 && waited < 1000) begin
      step();
      waited++;
    end
    check_int("wait_for_x300", (waited < 1000) ? 1 : 0, 1);
    async_reset(2, 2);
    step();
    check("dflt_post_rst_e1", get_obs(0), mk(799, 524, 0, 1, 1, 0, 0));
    step();
    check("dflt_post_rst_e2", get_obs(0), mk(0, 0, 1, 1, 1, 1, 1));
    step();
    check("dflt_post_rst_e3", get_obs(0), mk(0, 0, 1, 1, 1, 0, 0));

    // Random run lengths with asynchronous resets at random points.
    for (int r = 0; r < 6; r++) begin
      int len;
      len = int'($urandom_range(50, 700));
      for (int i = 0; i < len; i++) step();
      async_reset(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
    end
    for (int i = 0; i < 400; i++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
Timing generator directly upstream of the VGA colour stage. It derives the pixel-rate enable from the system clock and runs the horizontal and vertical counters. It produces hsync/vsync, the video_on window consumed by the colour stage, the current pixel coordinates, and a frame-start strobe. Defaults give 640x480 at 60 Hz from a 50 MHz clock.

Parameters:
CLK_DIV, 2, system clocks per pixel (>=1); 50 MHz / 2 = 25 MHz pixel rate
H_DISPLAY, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISPLAY, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CNT_W, 10, counter/coordinate width; 2^CNT_W must be >= H_TOTAL and >= V_TOTAL

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
hsync  output  1  horizontal sync, active at SYNC_POL
vsync  output  1  vertical sync, active at SYNC_POL
video_on  output  1  high while the current pixel is inside the visible area
p_tick  output  1  one-clk pulse marking a new pixel on the outputs
pixel_x  output  CNT_W  current horizontal count
pixel_y  output  CNT_W  current vertical count
frame_start  output  1  one-clk pulse when the counters enter (0,0)

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. It acts immediately, with no clock edge.
- Totals: H_TOTAL = H_DISPLAY+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_DISPLAY+V_FP+V_SYNC+V_BP (525).
- Divider: div counts 0..CLK_DIV-1 and wraps.
- Advance edge: the edge at which div == CLK_DIV-1. On it, div -> 0, counters advance, and p_tick is registered 1 for the next cycle only. On every other edge p_tick = 0.
- CLK_DIV = 1: every edge is an advance edge, so p_tick stays 1 from the first edge after reset.
- Horizontal count: h increments per advance edge and wraps H_TOTAL-1 -> 0.
- Vertical count: v increments only on the h wrap and wraps V_TOTAL-1 -> 0. Simultaneous h and v wrap go to (0,0) in one step.
- Output registration: all outputs are registered and computed from the next-state counter values. pixel_x, pixel_y, video_on, hsync, vsync, p_tick and frame_start therefore change on the same edge and are mutually aligned (zero relative latency).
- video_on = (h < H_DISPLAY) && (v < V_DISPLAY).
- hsync = SYNC_POL when h is in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] (656..751); otherwise ~SYNC_POL.
- vsync = SYNC_POL when v is in [V_DISPLAY+V_FP, V_DISPLAY+V_FP+V_SYNC-1] (490..491), for all h of those lines; otherwise ~SYNC_POL.
- frame_start = 1 for exactly the one clk in which (pixel_x, pixel_y) first equals (0,0). It always coincides with p_tick = 1.
- Between advance edges all outputs except p_tick hold their values.
- Reset values:
  - div = 0.
  - h = H_TOTAL-1 and v = V_TOTAL-1, so pixel_x = 799 and pixel_y = 524.
  - video_on = 0, p_tick = 0, frame_start = 0.
  - hsync = vsync = ~SYNC_POL.
  These are the consistent decode of position (799,524), so the first advance after reset enters (0,0) and fires frame_start.
- After reset release: the first advance edge is the CLK_DIV-th rising edge.
- Reset asserted mid-frame: all state is immediately forced to the reset values. There is no partial-frame completion. On release, timing restarts as above.
- No other inputs exist. The block free-runs and has no stall or handshake; consumers sample on p_tick.

Test Plan:
- Reset and startup (CLK_DIV=2): hold reset low -> pixel_x=799, pixel_y=524, video_on=0, hsync=vsync=1, p_tick=0. Release reset -> on the 2nd rising edge: pixel=(0,0), video_on=1, p_tick=1, frame_start=1. On the 3rd edge: p_tick=0, frame_start=0, pixel still (0,0).
- Line timing: count p_ticks across line 0 -> video_on high for exactly 640 ticks then low for 160. hsync low exactly for pixel_x 656..751 (96 ticks). Line period = 800 ticks = 1600 clks.
- Frame timing: vsync low for the whole of lines 490 and 491 (1600 ticks). video_on never high for pixel_y >= 480. Frame = 420000 ticks. frame_start fires exactly once per frame, and p_tick fires at every second clk throughout.
- Wrap boundaries:
  - (799,479) -> (0,480): video_on stays 0.
  - (799,524) -> (0,0): frame_start=1, video_on=1.
  - (639,y<480) -> (640,y): video_on 1 -> 0 on the same edge.
- Mid-frame reset: assert reset asynchronously (between edges) at pixel (300,200) -> outputs switch to the reset values before the next clk edge. After release, (0,0) and frame_start appear on the 2nd edge.
- CLK_DIV=1 build: p_tick=1 from the first edge after reset release, first edge gives (0,0) with frame_start=1, and the line period is 800 clks.
